// File: rtl/prog_mem_pp_ctrl_if.sv
// rtl/prog_mem_pp_ctrl_if.sv - CPU fetch and parallel-programming pin bundle
interface prog_mem_pp_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] PC;
  logic              PC_RD;
  logic [15:0]       INSTR;
  logic              INSTR_VLD;
  logic              XTAL1;
  logic [1:0]        XA;
  logic              BS1;
  logic              WR;
  logic              OE;
  logic [7:0]        DATA_IN;
  logic [7:0]        DATA_OUT;
  logic              DATA_OE;
  logic              RDY;
  logic              CMD_ERR;

  modport master (
    output PC, PC_RD, XTAL1, XA, BS1, WR, OE, DATA_IN,
    input  INSTR, INSTR_VLD, DATA_OUT, DATA_OE, RDY, CMD_ERR
  );

  modport slave (
    input  PC, PC_RD, XTAL1, XA, BS1, WR, OE, DATA_IN,
    output INSTR, INSTR_VLD, DATA_OUT, DATA_OE, RDY, CMD_ERR
  );
endinterface

// File: rtl/prog_mem_pp_ctrl.sv
// rtl/prog_mem_pp_ctrl.sv - paged program flash model with parallel-programming controller
module prog_mem_pp_ctrl #(
  parameter int PAGE_WORDS    = 64,
  parameter int NUM_PAGES     = 256,
  parameter int ADDR_W        = $clog2(PAGE_WORDS * NUM_PAGES),
  parameter int PROG_CYCLES   = 64,
  parameter int CERASE_CYCLES = 256
) (
  input logic               clk,
  input logic               rst_n,
  prog_mem_pp_ctrl_if.slave bus
);
  localparam int DEPTH = PAGE_WORDS * NUM_PAGES;
  localparam int OFF_W = $clog2(PAGE_WORDS);
  localparam int CNT_W = 16;
  localparam logic [7:0] CMD_CERASE = 8'h80;
  localparam logic [7:0] CMD_PROG   = 8'h10;
  localparam logic [7:0] CMD_READ   = 8'h02;

  typedef enum logic [1:0] {IDLE, PROG, CERASE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_err_q, cmd_err_d;
  logic [2:0]        xtal_sync_q, wr_sync_q, oe_sync_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        low_hold_q;
  logic [15:0]       page_buf_q [PAGE_WORDS];
  // Stored inverted: an all-zero (uninitialised) array reads back as erased FFFF.
  logic [15:0]       mem_n [DEPTH];
  logic [15:0]       instr_q;
  logic              instr_vld_q;
  logic [7:0]        data_out_q;
  logic              data_oe_q;
  logic              xtal_rise, wr_fall, oe_active, cmd_load;
  logic              prog_done, erase_done, rd_en;
  logic [15:0]       rd_word;

  assign xtal_rise  = xtal_sync_q[1] & ~xtal_sync_q[2];
  assign wr_fall    = ~wr_sync_q[1] & wr_sync_q[2];
  assign oe_active  = ~oe_sync_q[1];
  assign cmd_load   = xtal_rise && (bus.XA == 2'b10);
  assign prog_done  = (state_q == PROG) && (cnt_q == '0);
  assign erase_done = (state_q == CERASE) && (cnt_q == '0);
  assign rd_en      = oe_active && (cmd_q == CMD_READ) && (state_q == IDLE);
  assign rd_word    = ~mem_n[addr_q];

  assign bus.RDY       = (state_q == IDLE);
  assign bus.CMD_ERR   = cmd_err_q;
  assign bus.INSTR     = instr_q;
  assign bus.INSTR_VLD = instr_vld_q;
  assign bus.DATA_OUT  = data_out_q;
  assign bus.DATA_OE   = data_oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xtal_sync_q <= 3'b000;
      wr_sync_q   <= 3'b111;
      oe_sync_q   <= 3'b111;
    end else begin
      xtal_sync_q <= {xtal_sync_q[1:0], bus.XTAL1};
      wr_sync_q   <= {wr_sync_q[1:0], bus.WR};
      oe_sync_q   <= {oe_sync_q[1:0], bus.OE};
    end
  end

  // WR sees cmd_d so a command latched on the same cycle is the one executed.
  always_comb begin
    cmd_d  = cmd_load ? bus.DATA_IN : cmd_q;
    addr_d = addr_q;
    if (xtal_rise && (bus.XA == 2'b00)) begin
      if (bus.BS1) addr_d[ADDR_W-1:8] = bus.DATA_IN[ADDR_W-9:0];
      else         addr_d[7:0]        = bus.DATA_IN;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_err_d = cmd_err_q;
    if (cmd_load) cmd_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_fall) begin
          if (cmd_d == CMD_PROG) begin
            state_d = PROG;
            cnt_d   = CNT_W'(PROG_CYCLES - 1);
          end else if (cmd_d == CMD_CERASE) begin
            state_d = CERASE;
            cnt_d   = CNT_W'(CERASE_CYCLES - 1);
          end else if (cmd_d != CMD_READ) begin
            cmd_err_d = 1'b1;
          end
        end
      end
      PROG, CERASE: begin
        if (wr_fall) cmd_err_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cmd_q      <= '0;
      low_hold_q <= '0;
      for (int i = 0; i < PAGE_WORDS; i++) page_buf_q[OFF_W'(i)] <= 16'hFFFF;
    end else begin
      addr_q <= addr_d;
      cmd_q  <= cmd_d;
      if (xtal_rise && (bus.XA == 2'b01)) begin
        if (bus.BS1) page_buf_q[addr_q[OFF_W-1:0]] <= {bus.DATA_IN, low_hold_q};
        else         low_hold_q <= bus.DATA_IN;
      end
      if (prog_done) begin
        for (int i = 0; i < PAGE_WORDS; i++) page_buf_q[OFF_W'(i)] <= 16'hFFFF;
      end
    end
  end

  // Programming can only clear bits; in inverted storage that is an OR.
  always_ff @(posedge clk) begin
    if (erase_done) begin
      for (int i = 0; i < DEPTH; i++) mem_n[ADDR_W'(i)] <= '0;
    end else if (prog_done) begin
      for (int w = 0; w < PAGE_WORDS; w++) begin
        mem_n[{addr_q[ADDR_W-1:OFF_W], OFF_W'(w)}] <=
          mem_n[{addr_q[ADDR_W-1:OFF_W], OFF_W'(w)}] | ~page_buf_q[OFF_W'(w)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      if (bus.PC_RD && (state_q == IDLE)) begin
        instr_q     <= ~mem_n[bus.PC];
        instr_vld_q <= 1'b1;
      end else begin
        instr_vld_q <= 1'b0;
      end
      data_oe_q  <= rd_en;
      data_out_q <= rd_en ? (bus.BS1 ? rd_word[15:8] : rd_word[7:0]) : 8'h00;
    end
  end
endmodule

// File: tb/tb_prog_mem_pp_ctrl.sv
// tb/tb_prog_mem_pp_ctrl.sv - self-checking bench for prog_mem_pp_ctrl
module tb_prog_mem_pp_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  prog_mem_pp_ctrl_if #(.ADDR_W(14)) bus ();
  prog_mem_pp_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] model_mem [16384];
  logic [15:0] model_buf [64];
  logic [13:0] model_addr;
  logic [7:0]  model_lo;

  task automatic xtal_op(input logic [1:0] xa, input logic bs1, input logic [7:0] d);
    @(negedge clk);
    bus.XA = xa; bus.BS1 = bs1; bus.DATA_IN = d; bus.XTAL1 = 1'b1;
    repeat (4) @(negedge clk);
    bus.XTAL1 = 1'b0; bus.XA = 2'b11;
    repeat (3) @(negedge clk);
    if (xa == 2'b00) begin
      if (bs1) model_addr[13:8] = d[5:0];
      else     model_addr[7:0]  = d;
    end else if (xa == 2'b01) begin
      if (bs1) model_buf[model_addr[5:0]] = {d, model_lo};
      else     model_lo = d;
    end
  endtask

  task automatic load_cmd(input logic [7:0] c);
    xtal_op(2'b10, 1'b0, c);
  endtask

  task automatic load_addr(input logic [13:0] a);
    xtal_op(2'b00, 1'b0, a[7:0]);
    xtal_op(2'b00, 1'b1, {2'b00, a[13:8]});
  endtask

  task automatic load_word(input logic [13:0] a, input logic [15:0] w);
    load_addr(a);
    xtal_op(2'b01, 1'b0, w[7:0]);
    xtal_op(2'b01, 1'b1, w[15:8]);
  endtask

  task automatic apply_program();
    for (int i = 0; i < 64; i++) begin
      model_mem[{model_addr[13:6], 6'(i)}] &= model_buf[i];
      model_buf[i] = 16'hFFFF;
    end
  endtask

  task automatic run_wr(output int busy);
    int wait_n = 0;
    busy = 0;
    @(negedge clk);
    bus.WR = 1'b0;
    while (bus.RDY !== 1'b0 && wait_n < 10) begin
      wait_n++;
      @(negedge clk);
    end
    while (bus.RDY === 1'b0 && busy < 5000) begin
      busy++;
      @(negedge clk);
    end
    bus.WR = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic fetch(input logic [13:0] a, output logic [15:0] d, output logic v);
    @(negedge clk);
    bus.PC = a; bus.PC_RD = 1'b1;
    @(negedge clk);
    d = bus.INSTR; v = bus.INSTR_VLD;
    bus.PC_RD = 1'b0;
  endtask

  task automatic readback(input logic [13:0] a, input logic bs1, output logic [7:0] d, output logic oe);
    load_addr(a);
    @(negedge clk);
    bus.BS1 = bs1; bus.OE = 1'b0;
    repeat (4) @(negedge clk);
    d = bus.DATA_OUT; oe = bus.DATA_OE;
    bus.OE = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.RDY, bus.INSTR, bus.INSTR_VLD, bus.DATA_OUT, bus.DATA_OE, bus.CMD_ERR} !== {1'b1, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b instr=%h vld=%b dout=%h doe=%b err=%b expected 1 0000 0 00 0 0",
               bus.RDY, bus.INSTR, bus.INSTR_VLD, bus.DATA_OUT, bus.DATA_OE, bus.CMD_ERR);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_powerup();
    logic [15:0] d; logic v;
    logic [13:0] pcs [2];
    pcs[0] = 14'd0; pcs[1] = 14'd16383;
    foreach (pcs[k]) begin
      fetch(pcs[k], d, v);
      n_cmp++;
      if (v !== 1'b1 || d !== model_mem[pcs[k]]) begin
        n_err++;
        $display("FAIL powerup_fetch pc=%h: got vld=%b instr=%h expected vld=1 instr=%h", pcs[k], v, d, model_mem[pcs[k]]);
      end
    end
    n_cmp++;
    if (bus.RDY !== 1'b1) begin n_err++; $display("FAIL powerup_rdy: got %b expected 1", bus.RDY); end
  endtask

  task automatic test_page_program();
    int busy; logic [15:0] d; logic v;
    logic [13:0] pcs [3];
    pcs[0] = 14'h40; pcs[1] = 14'h43; pcs[2] = 14'h41;
    load_cmd(8'h10);
    load_word(14'h40, 16'h1234);
    load_word(14'h43, 16'hABCD);
    run_wr(busy);
    apply_program();
    n_cmp++;
    if (busy !== 64) begin n_err++; $display("FAIL prog_busy_cycles: got %0d expected 64", busy); end
    foreach (pcs[k]) begin
      fetch(pcs[k], d, v);
      n_cmp++;
      if (v !== 1'b1 || d !== model_mem[pcs[k]]) begin
        n_err++;
        $display("FAIL prog_fetch pc=%h: got vld=%b instr=%h expected vld=1 instr=%h", pcs[k], v, d, model_mem[pcs[k]]);
      end
    end
  endtask

  task automatic test_and_semantics();
    int busy; logic [15:0] d; logic v;
    load_cmd(8'h10);
    load_word(14'h40, 16'h00FF);
    run_wr(busy);
    apply_program();
    fetch(14'h40, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== model_mem[14'h40]) begin
      n_err++;
      $display("FAIL and_semantics: got vld=%b instr=%h expected vld=1 instr=%h", v, d, model_mem[14'h40]);
    end
  endtask

  task automatic test_readback_erase();
    int busy; logic [7:0] d; logic oe;
    logic [13:0] a;
    load_cmd(8'h02);
    for (int b = 1; b >= 0; b--) begin
      readback(14'h43, b[0], d, oe);
      n_cmp++;
      if (oe !== 1'b1 || d !== (b[0] ? model_mem[14'h43][15:8] : model_mem[14'h43][7:0])) begin
        n_err++;
        $display("FAIL readback_0x43 bs1=%0d: got oe=%b data=%h expected oe=1 data=%h", b, oe, d,
                 b[0] ? model_mem[14'h43][15:8] : model_mem[14'h43][7:0]);
      end
    end
    load_cmd(8'h80);
    run_wr(busy);
    for (int i = 0; i < 16384; i++) model_mem[i] = 16'hFFFF;
    n_cmp++;
    if (busy !== 256) begin n_err++; $display("FAIL erase_busy_cycles: got %0d expected 256", busy); end
    load_cmd(8'h02);
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 14'h43 : (k == 1) ? 14'h40 : 14'($urandom_range(0, 16383));
      readback(a, k[0], d, oe);
      n_cmp++;
      if (oe !== 1'b1 || d !== (k[0] ? model_mem[a][15:8] : model_mem[a][7:0])) begin
        n_err++;
        $display("FAIL erase_readback a=%h: got oe=%b data=%h expected oe=1 data=ff", a, oe, d);
      end
    end
  endtask

  task automatic test_cmd_err();
    int busy; logic [7:0] d; logic oe;
    load_cmd(8'h55);
    run_wr(busy);
    n_cmp++;
    if (bus.CMD_ERR !== 1'b1 || busy !== 0) begin
      n_err++;
      $display("FAIL unknown_cmd: got err=%b busy=%0d expected err=1 busy=0", bus.CMD_ERR, busy);
    end
    load_cmd(8'h10);
    n_cmp++;
    if (bus.CMD_ERR !== 1'b0) begin n_err++; $display("FAIL cmd_err_clear: got %b expected 0", bus.CMD_ERR); end
    readback(14'h10, 1'b0, d, oe);
    n_cmp++;
    if (oe !== 1'b0) begin n_err++; $display("FAIL readback_wrong_cmd: got oe=%b expected 0", oe); end
  endtask

  task automatic test_busy_conflicts();
    int busy = 0; int wait_n = 0; int stall_bad = 0;
    logic [15:0] d; logic v;
    load_cmd(8'h10);
    load_word(14'h101, 16'h5A5A);
    @(negedge clk);
    bus.WR = 1'b0; bus.PC = 14'h101;
    while (bus.RDY !== 1'b0 && wait_n < 10) begin wait_n++; @(negedge clk); end
    while (bus.RDY === 1'b0 && busy < 5000) begin
      if (bus.INSTR_VLD !== 1'b0) stall_bad++;
      if (busy == 2) bus.WR = 1'b1;
      if (busy == 5) bus.PC_RD = 1'b1;
      if (busy == 8) bus.WR = 1'b0;
      busy++;
      @(negedge clk);
    end
    apply_program();
    n_cmp++;
    if (busy !== 64 || stall_bad !== 0) begin
      n_err++;
      $display("FAIL busy_conflict_timing: got busy=%0d stalled_vld=%0d expected 64 and 0", busy, stall_bad);
    end
    n_cmp++;
    if (bus.CMD_ERR !== 1'b1) begin n_err++; $display("FAIL busy_wr_err: got %b expected 1", bus.CMD_ERR); end
    @(negedge clk);
    n_cmp++;
    if (bus.INSTR_VLD !== 1'b1 || bus.INSTR !== model_mem[14'h101]) begin
      n_err++;
      $display("FAIL held_fetch_after_busy: got vld=%b instr=%h expected vld=1 instr=%h", bus.INSTR_VLD, bus.INSTR, model_mem[14'h101]);
    end
    bus.PC_RD = 1'b0; bus.WR = 1'b1;
    repeat (3) @(negedge clk);
    fetch(14'h100, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== model_mem[14'h100]) begin
      n_err++;
      $display("FAIL busy_untouched_word: got vld=%b instr=%h expected vld=1 instr=%h", v, d, model_mem[14'h100]);
    end
  endtask

  task automatic test_random();
    int busy; logic [15:0] d; logic v; logic [7:0] b; logic oe;
    logic [13:0] base, a;
    for (int it = 0; it < 4; it++) begin
      base = {8'($urandom_range(0, 255)), 6'd0};
      load_cmd(8'h10);
      for (int k = 0; k < 3; k++) load_word(base | 14'($urandom_range(0, 63)), 16'($urandom));
      run_wr(busy);
      apply_program();
      n_cmp++;
      if (busy !== 64) begin n_err++; $display("FAIL rand_busy it=%0d: got %0d expected 64", it, busy); end
      for (int k = 0; k < 3; k++) begin
        a = base | 14'($urandom_range(0, 63));
        if (k == 0) a = model_addr;
        fetch(a, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== model_mem[a]) begin
          n_err++;
          $display("FAIL rand_fetch a=%h: got vld=%b instr=%h expected vld=1 instr=%h", a, v, d, model_mem[a]);
        end
      end
      load_cmd(8'h02);
      a = base | 14'($urandom_range(0, 63));
      readback(a, it[0], b, oe);
      n_cmp++;
      if (oe !== 1'b1 || b !== (it[0] ? model_mem[a][15:8] : model_mem[a][7:0])) begin
        n_err++;
        $display("FAIL rand_readback a=%h: got oe=%b data=%h expected oe=1 data=%h", a, oe, b,
                 it[0] ? model_mem[a][15:8] : model_mem[a][7:0]);
      end
    end
  endtask

  task automatic test_reset_mid_prog();
    int wait_n = 0; logic [15:0] d; logic v;
    logic [13:0] pcs [2];
    pcs[0] = 14'h85; pcs[1] = 14'h80;
    load_cmd(8'h10);
    load_word(14'h85, 16'h0F0F);
    load_word(14'h80, 16'h1111);
    @(negedge clk);
    bus.WR = 1'b0;
    while (bus.RDY !== 1'b0 && wait_n < 10) begin wait_n++; @(negedge clk); end
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.RDY !== 1'b1 || bus.CMD_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_prog_rdy: got rdy=%b err=%b expected rdy=1 err=0", bus.RDY, bus.CMD_ERR);
    end
    for (int i = 0; i < 64; i++) model_buf[i] = 16'hFFFF;
    model_addr = '0;
    bus.WR = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    foreach (pcs[k]) begin
      fetch(pcs[k], d, v);
      n_cmp++;
      if (v !== 1'b1 || d !== model_mem[pcs[k]]) begin
        n_err++;
        $display("FAIL reset_mid_prog_page pc=%h: got vld=%b instr=%h expected vld=1 instr=%h", pcs[k], v, d, model_mem[pcs[k]]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PC = '0; bus.PC_RD = 1'b0; bus.XTAL1 = 1'b0; bus.XA = 2'b11; bus.BS1 = 1'b0;
    bus.WR = 1'b1; bus.OE = 1'b1; bus.DATA_IN = '0;
    for (int i = 0; i < 16384; i++) model_mem[i] = 16'hFFFF;
    for (int i = 0; i < 64; i++) model_buf[i] = 16'hFFFF;
    model_addr = '0; model_lo = '0;
    test_reset();
    test_powerup();
    test_page_program();
    test_and_semantics();
    test_readback_erase();
    test_cmd_err();
    test_busy_conflicts();
    test_random();
    test_reset_mid_prog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
